// File: rtl/frog_pkg.sv
// Shared constants and FSM state encoding for the frog game collision controller.
package frog_pkg;

  localparam int GRID_W    = 20;
  localparam int POS_W     = 5;
  localparam int ROW_W     = 4;
  localparam int MAX_LEVEL = 15;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_HIT   = 2'd1,
    S_LEVEL = 2'd2,
    S_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/lane_hit.sv
// Single-lane collision compare: frog on this lane's row and car in the frog's column.
// COLLISION_WIDE_HITBOX_EN widens the hitbox to the neighbouring columns, wrapping 19<->0.
module lane_hit
  import frog_pkg::*;
#(
  parameter int ROW = 1
) (
  input  logic [POS_W-1:0] car_x,
  input  logic [POS_W-1:0] frog_x,
  input  logic [ROW_W-1:0] frog_y,
  output logic             hit
);

  logic row_match;
  logic col_match;

`ifdef COLLISION_WIDE_HITBOX_EN
  logic [POS_W-1:0] left_x;
  logic [POS_W-1:0] right_x;

  always_comb begin
    left_x    = (frog_x == '0) ? POS_W'(GRID_W - 1) : frog_x - 1'b1;
    right_x   = (frog_x == POS_W'(GRID_W - 1)) ? '0 : frog_x + 1'b1;
    col_match = (car_x == frog_x) || (car_x == left_x) || (car_x == right_x);
  end
`else
  always_comb col_match = (car_x == frog_x);
`endif

  always_comb begin
    row_match = (32'(frog_y) == ROW);
    hit       = row_match & col_match;
  end

endmodule

// File: rtl/collision_ctrl.sv
// Frog game referee: detects car collisions and goal arrival, tracks lives/level, sequences freezes.
// Optional COLLISION_WIDE_HITBOX_EN (inside lane_hit) enables a +/-1 column hitbox.
module collision_ctrl
  import frog_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int LANE_ROW0   = 1,
  parameter int START_LIVES = 3,
  parameter int HIT_HOLD    = 8
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_tick,
  input  logic [NUM_LANES*5-1:0]   i_car_x,
  input  logic [4:0]               i_frog_x,
  input  logic [3:0]               i_frog_y,
  input  logic                     i_start,
  output logic                     o_hit,
  output logic                     o_level_up,
  output logic                     o_frog_reset,
  output logic [1:0]               o_lives,
  output logic [3:0]               o_level,
  output logic                     o_freeze,
  output logic                     o_game_over
);

  logic [NUM_LANES-1:0] lane_hits;
  logic                 any_hit;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_hit #(.ROW(LANE_ROW0 + k)) u_lane_hit (
      .car_x  (i_car_x[5*k +: POS_W]),
      .frog_x (i_frog_x),
      .frog_y (i_frog_y),
      .hit    (lane_hits[k])
    );
  end

  assign any_hit = |lane_hits;

  state_t     state, state_nx;
  logic [1:0] lives, lives_nx;
  logic [3:0] level, level_nx;
  logic [7:0] hold, hold_nx;
  logic       hit_nx, level_up_nx, frog_reset_nx, freeze_nx, game_over_nx;

  always_comb begin
    state_nx      = state;
    lives_nx      = lives;
    level_nx      = level;
    hold_nx       = hold;
    hit_nx        = 1'b0;
    level_up_nx   = 1'b0;
    frog_reset_nx = 1'b0;

    unique case (state)
      S_PLAY: begin
        if (i_tick) begin
          // Collision wins over goal; the lane rows never include row 0 anyway.
          if (any_hit) begin
            hit_nx = 1'b1;
            if (lives <= 2'd1) begin
              lives_nx = 2'd0;
              state_nx = S_OVER;
            end else begin
              lives_nx = lives - 2'd1;
              hold_nx  = 8'(HIT_HOLD);
              state_nx = S_HIT;
            end
          end else if (i_frog_y == '0) begin
            level_up_nx   = 1'b1;
            frog_reset_nx = 1'b1;
            if (level < 4'(MAX_LEVEL)) level_nx = level + 4'd1;
            state_nx = S_LEVEL;
          end
        end
      end
      S_LEVEL: begin
        if (i_tick) state_nx = S_PLAY;
      end
      S_HIT: begin
        if (i_tick) begin
          if (hold <= 8'd1) begin
            hold_nx       = 8'd0;
            frog_reset_nx = 1'b1;
            state_nx      = S_PLAY;
          end else begin
            hold_nx = hold - 8'd1;
          end
        end
      end
      S_OVER: begin
        if (i_start) begin
          lives_nx      = 2'(START_LIVES);
          level_nx      = 4'd1;
          frog_reset_nx = 1'b1;
          state_nx      = S_PLAY;
        end
      end
      default: state_nx = S_PLAY;
    endcase

    freeze_nx    = (state_nx == S_HIT) || (state_nx == S_OVER);
    game_over_nx = (state_nx == S_OVER);
  end

  // Register stage: every output is a flop, one cycle after the sampled tick.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= S_PLAY;
      lives        <= 2'(START_LIVES);
      level        <= 4'd1;
      hold         <= 8'd0;
      o_hit        <= 1'b0;
      o_level_up   <= 1'b0;
      o_frog_reset <= 1'b0;
      o_freeze     <= 1'b0;
      o_game_over  <= 1'b0;
    end else begin
      state        <= state_nx;
      lives        <= lives_nx;
      level        <= level_nx;
      hold         <= hold_nx;
      o_hit        <= hit_nx;
      o_level_up   <= level_up_nx;
      o_frog_reset <= frog_reset_nx;
      o_freeze     <= freeze_nx;
      o_game_over  <= game_over_nx;
    end
  end

  assign o_lives = lives;
  assign o_level = level;

endmodule

// File: tb/tb_collision_ctrl.sv
// Self-checking bench for collision_ctrl: directed scenarios plus randomized play against a rule-level model.
module tb_collision_ctrl;

  localparam int NL   = 4;
  localparam int ROW0 = 1;
  localparam int SL   = 3;
  localparam int HH   = 8;

  logic          clk = 1'b0;
  logic          rst, tick, start;
  logic [NL*5-1:0] car_x;
  logic [4:0]    fx;
  logic [3:0]    fy;
  logic          o_hit, o_level_up, o_frog_reset, o_freeze, o_game_over;
  logic [1:0]    o_lives;
  logic [3:0]    o_level;
  logic [10:0]   obs;

  int car[NL];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: game phase as plain integers.
  int m_mode;   // 0 play, 1 hit hold, 2 level pause, 3 game over
  int m_lives, m_level, m_hold;
  bit e_hit, e_up, e_fr;

  always #5 clk = ~clk;

  collision_ctrl #(
    .NUM_LANES(NL), .LANE_ROW0(ROW0), .START_LIVES(SL), .HIT_HOLD(HH)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_tick(tick), .i_car_x(car_x),
    .i_frog_x(fx), .i_frog_y(fy), .i_start(start),
    .o_hit(o_hit), .o_level_up(o_level_up), .o_frog_reset(o_frog_reset),
    .o_lives(o_lives), .o_level(o_level), .o_freeze(o_freeze), .o_game_over(o_game_over)
  );

  assign obs = {o_hit, o_level_up, o_frog_reset, o_lives, o_level, o_freeze, o_game_over};

  function automatic logic [10:0] expv();
    return {e_hit, e_up, e_fr, 2'(m_lives), 4'(m_level),
            (m_mode == 1 || m_mode == 3), (m_mode == 3)};
  endfunction

  function automatic bit collides();
    for (int k = 0; k < NL; k++) begin
      if (int'(fy) == ROW0 + k) begin
        int d;
        d = (car[k] - int'(fx) + 20) % 20;
`ifdef COLLISION_WIDE_HITBOX_EN
        if (d == 0 || d == 1 || d == 19) return 1'b1;
`else
        if (d == 0) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    e_hit = 0; e_up = 0; e_fr = 0;
    if (rst) begin
      m_mode = 0; m_lives = SL; m_level = 1; m_hold = 0;
    end else begin
      case (m_mode)
        0: if (tick) begin
          if (collides()) begin
            e_hit = 1;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = 3;
            else begin m_mode = 1; m_hold = HH; end
          end else if (fy == 0) begin
            e_up = 1; e_fr = 1;
            m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
            m_mode = 2;
          end
        end
        1: if (tick) begin
          m_hold = m_hold - 1;
          if (m_hold == 0) begin e_fr = 1; m_mode = 0; end
        end
        2: if (tick) m_mode = 0;
        default: if (start) begin
          m_lives = SL; m_level = 1; e_fr = 1; m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic t, input logic s);
    rst = r; tick = t; start = s;
    for (int k = 0; k < NL; k++) car_x[k*5 +: 5] = 5'(car[k]);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NL; k++) car[k] = 10;
    fx = 0; fy = 9;
    drive(1, 1, 1);
    n_vec++;
    if (obs !== expv()) begin n_bad++; $display("FAIL reset: got %b want %b", obs, expv()); end
    drive(0, 0, 0);
    n_vec++;
    if (obs !== 11'b000_11_0001_0_0) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs, 11'b000_11_0001_0_0); end
  endtask

  task automatic test_hit_hold();
    int ticks_frozen;
    bit seen_fr;
    logic was_frozen;
    drive(1, 0, 0);
    car = '{15, 7, 15, 15};
    fx = 7; fy = 2;
    drive(0, 1, 0);
    n_vec++;
    if (obs !== expv() || o_hit !== 1'b1 || o_lives !== 2'd2 || o_freeze !== 1'b1) begin
      n_bad++; $display("FAIL hit_pulse: got %b want %b", obs, expv());
    end
    ticks_frozen = 0; seen_fr = 0;
    for (int i = 0; i < 60 && !seen_fr; i++) begin
      was_frozen = o_freeze;
      drive(0, 1'(i % 2), 0);
      if (tick && was_frozen) ticks_frozen++;
      n_vec++;
      if (obs !== expv()) begin n_bad++; $display("FAIL hit_hold: got %b want %b", obs, expv()); end
      if (o_frog_reset) seen_fr = 1;
    end
    n_vec++;
    if (!seen_fr || ticks_frozen != HH) begin
      n_bad++; $display("FAIL hold_len: got %0d ticks (reset seen %0d) want %0d", ticks_frozen, seen_fr, HH);
    end
  endtask

  task automatic test_level_sat();
    drive(1, 0, 0);
    fx = 0; fy = 0;
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 0);
      n_vec++;
      if (obs !== expv() || o_level_up !== 1'b1) begin n_bad++; $display("FAIL goal: got %b want %b", obs, expv()); end
      drive(0, 1, 0);
      n_vec++;
      if (obs !== expv()) begin n_bad++; $display("FAIL level_pause: got %b want %b", obs, expv()); end
    end
    n_vec++;
    if (o_level !== 4'd15) begin n_bad++; $display("FAIL level_sat: got %0d want 15", o_level); end
  endtask

  task automatic test_game_over();
    drive(1, 0, 0);
    car = '{3, 7, 3, 3};
    fx = 7; fy = 2;
    drive(0, 0, 1);
    n_vec++;
    if (obs !== expv()) begin n_bad++; $display("FAIL start_ignored: got %b want %b", obs, expv()); end
    for (int h = 0; h < 3; h++) begin
      drive(0, 1, 0);
      n_vec++;
      if (obs !== expv()) begin n_bad++; $display("FAIL hit_%0d: got %b want %b", h, obs, expv()); end
      for (int i = 0; i < 20 && m_mode == 1; i++) begin
        drive(0, 1, 0);
        n_vec++;
        if (obs !== expv()) begin n_bad++; $display("FAIL over_hold: got %b want %b", obs, expv()); end
      end
    end
    n_vec++;
    if (o_game_over !== 1'b1 || o_lives !== 2'd0) begin
      n_bad++; $display("FAIL game_over: got over=%b lives=%0d want over=1 lives=0", o_game_over, o_lives);
    end
    drive(0, 1, 0);
    n_vec++;
    if (obs !== expv()) begin n_bad++; $display("FAIL over_tick: got %b want %b", obs, expv()); end
    drive(0, 0, 1);
    n_vec++;
    if (obs !== expv() || o_lives !== 2'd3 || o_level !== 4'd1 || o_frog_reset !== 1'b1) begin
      n_bad++; $display("FAIL restart: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_wide_hitbox();
    drive(1, 0, 0);
    car = '{19, 5, 5, 5};
    fx = 0; fy = 1;
    drive(0, 1, 0);
    n_vec++;
`ifdef COLLISION_WIDE_HITBOX_EN
    if (o_hit !== 1'b1 || obs !== expv()) begin n_bad++; $display("FAIL wrap_hit: got %b want %b", obs, expv()); end
`else
    if (o_hit !== 1'b0 || obs !== expv()) begin n_bad++; $display("FAIL wrap_hit: got %b want %b", obs, expv()); end
`endif
    drive(1, 0, 0);
    car = '{2, 5, 5, 5};
    drive(0, 1, 0);
    n_vec++;
    if (o_hit !== 1'b0 || obs !== expv()) begin n_bad++; $display("FAIL far_car: got %b want %b", obs, expv()); end
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 0, 0);
    car = '{9, 9, 9, 9};
    fx = 9; fy = 3;
    drive(0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0);
    n_vec++;
    if (obs !== expv() || o_freeze !== 1'b1) begin n_bad++; $display("FAIL mid_hold: got %b want %b", obs, expv()); end
    drive(1, 1, 1);
    n_vec++;
    if (obs !== expv() || o_lives !== 2'd3 || o_level !== 4'd1 || o_freeze !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold: got %b want %b", obs, expv());
    end
  endtask

  task automatic test_off_rows();
    int rows[3];
    rows = '{5, 6, 15};
    drive(1, 0, 0);
    car = '{5, 5, 5, 5};
    fx = 5;
    for (int i = 0; i < 3; i++) begin
      fy = 4'(rows[i]);
      drive(0, 1, 0);
      n_vec++;
      if (o_hit !== 1'b0 || obs !== expv()) begin n_bad++; $display("FAIL row_%0d: got %b want %b", rows[i], obs, expv()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NL; k++) car[k] = $urandom_range(0, 19);
      fy = 4'($urandom_range(0, 6));
      if (fy >= 1 && fy <= 4 && $urandom_range(0, 1) == 1) fx = 5'(car[fy - 1]);
      else fx = 5'($urandom_range(0, 19));
      drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      n_vec++;
      if (obs !== expv()) begin n_bad++; $display("FAIL random_%0d: got %b want %b", i, obs, expv()); end
    end
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; car_x = '0; fx = '0; fy = '0;
    m_mode = 0; m_lives = SL; m_level = 1; m_hold = 0;
    test_reset();
    test_hit_hold();
    test_level_sat();
    test_game_over();
    test_wide_hitbox();
    test_reset_mid_hold();
    test_off_rows();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
